// File: rtl/vslc_timer_pkg.sv
// Shared encodings, state enum and reset defaults for the VSLC timer bank.
package vslc_timer_pkg;

  localparam logic [1:0] MODE_CYCLE     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT   = 2'd1;
  localparam logic [1:0] MODE_RETRIGGER = 2'd2;

  localparam logic [1:0] CFG_PERIOD_A = 2'd0;
  localparam logic [1:0] CFG_PERIOD_B = 2'd1;
  localparam logic [1:0] CFG_CTRL     = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PHASE_A = 2'd1,
    PHASE_B = 2'd2
  } timer_state_e;

  localparam int unsigned PERIOD_A_RST = 1;
  localparam int unsigned PERIOD_B_RST = 2;

endpackage

// File: rtl/vslc_timer_channel.sv
// One timer channel: config registers, power-of-two prescaler, phase FSM and
// registered out/running/done plus the live phase counter.
module vslc_timer_channel
  import vslc_timer_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  output logic             running,
  output logic             out,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);
  localparam int PRE_W = 2**DIV_W - 1;

  logic [CNT_W-1:0] period_a_reg, period_b_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       mode_reg;

  timer_state_e     state_reg, state_next;
  logic [CNT_W-1:0] act_a_reg, act_a_next, act_b_reg, act_b_next;
  logic [DIV_W-1:0] act_div_reg, act_div_next;
  logic [1:0]       act_mode_reg, act_mode_next;
  logic [PRE_W-1:0] pre_reg, pre_next, pre_mask;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next, done_reg, done_next, running_reg;
  logic             tick, restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_a_reg <= CNT_W'(PERIOD_A_RST);
      period_b_reg <= CNT_W'(PERIOD_B_RST);
      div_reg      <= '0;
      mode_reg     <= MODE_CYCLE;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_PERIOD_A: period_a_reg <= cfg_wdata;
        CFG_PERIOD_B: period_b_reg <= cfg_wdata;
        CFG_CTRL: begin
          div_reg  <= cfg_wdata[DIV_W-1:0];
          mode_reg <= cfg_wdata[DIV_W+1:DIV_W];
        end
        default: ;
      endcase
    end
  end

  // Tick when the prescaler reaches 2**div-1; div=0 ticks every clock.
  assign pre_mask = ~({PRE_W{1'b1}} << act_div_reg);
  assign tick     = (state_reg != IDLE) && (pre_reg == pre_mask);
  assign restart  = start && ((state_reg == IDLE) || (act_mode_reg == MODE_RETRIGGER));

  always_comb begin
    state_next    = state_reg;
    act_a_next    = act_a_reg;
    act_b_next    = act_b_reg;
    act_div_next  = act_div_reg;
    act_mode_next = act_mode_reg;
    pre_next      = pre_reg;
    cnt_next      = cnt_reg;
    out_next      = out_reg;
    done_next     = 1'b0;
    if (stop) begin
      state_next = IDLE;
      out_next   = 1'b0;
      cnt_next   = '0;
      pre_next   = '0;
    end else if (restart) begin
      act_a_next    = period_a_reg;
      act_b_next    = period_b_reg;
      act_div_next  = div_reg;
      act_mode_next = mode_reg;
      state_next    = PHASE_A;
      out_next      = 1'b0;
      cnt_next      = '0;
      pre_next      = '0;
    end else if (state_reg != IDLE) begin
      if (!tick) begin
        pre_next = pre_reg + 1'b1;
      end else begin
        pre_next = '0;
        if (state_reg == PHASE_A) begin
          if (cnt_reg == act_a_reg) begin
            out_next   = 1'b1;
            cnt_next   = '0;
            state_next = PHASE_B;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end else if (cnt_reg == act_b_reg) begin
          out_next = 1'b0;
          cnt_next = '0;
          if (act_mode_reg == MODE_CYCLE) begin
            act_a_next = period_a_reg;
            act_b_next = period_b_reg;
            state_next = PHASE_A;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      act_a_reg    <= '0;
      act_b_reg    <= '0;
      act_div_reg  <= '0;
      act_mode_reg <= MODE_CYCLE;
      pre_reg      <= '0;
      cnt_reg      <= '0;
      out_reg      <= 1'b0;
      done_reg     <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      act_a_reg    <= act_a_next;
      act_b_reg    <= act_b_next;
      act_div_reg  <= act_div_next;
      act_mode_reg <= act_mode_next;
      pre_reg      <= pre_next;
      cnt_reg      <= cnt_next;
      out_reg      <= out_next;
      done_reg     <= done_next;
      running_reg  <= (state_next != IDLE);
    end
  end

  assign running = running_reg;
  assign out     = out_reg;
  assign done    = done_reg;
  assign cnt     = cnt_reg;

endmodule

// File: rtl/vslc_timer_bank.sv
// Bank of CHANNELS timer channels with config decode. Define
// VSLC_TIMER_READBACK_EN to build the registered phase-counter readback.
module vslc_timer_bank
  import vslc_timer_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 10,
  parameter  int DIV_W    = 4,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_addr,
  input  logic [CNT_W-1:0]    cfg_wdata,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] running,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] done,
  input  logic [CH_W-1:0]     cnt_sel,
  output logic [CNT_W-1:0]    cnt_rdata
);
  logic [CHANNELS*CNT_W-1:0] ch_cnt_flat;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic ch_we;
    // Out-of-range cfg_ch matches no channel, so such writes are dropped.
    assign ch_we = cfg_we && (int'(cfg_ch) == gi);

    vslc_timer_channel #(
      .CNT_W (CNT_W),
      .DIV_W (DIV_W)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (ch_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .start     (start[gi]),
      .stop      (stop[gi]),
      .running   (running[gi]),
      .out       (out[gi]),
      .done      (done[gi]),
      .cnt       (ch_cnt_flat[gi*CNT_W +: CNT_W])
    );
  end

`ifdef VSLC_TIMER_READBACK_EN
  logic [CNT_W-1:0] rb_sel;
  logic [CNT_W-1:0] cnt_rdata_reg;

  always_comb begin
    rb_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(cnt_sel) == i) rb_sel = ch_cnt_flat[i*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_rdata_reg <= '0;
    else        cnt_rdata_reg <= rb_sel;
  end

  assign cnt_rdata = cnt_rdata_reg;
`else
  logic unused_rb;
  assign unused_rb = ^{cnt_sel, ch_cnt_flat};
  assign cnt_rdata = '0;
`endif

endmodule

// File: tb/tb_vslc_timer_bank.sv
// Scoreboard bench for vslc_timer_bank: expectations are queued per cycle as
// stimulus is issued and compared when the run reaches that cycle.
module tb_vslc_timer_bank;
  localparam int CHANNELS  = 4;
  localparam int CNT_W     = 10;
  localparam int DIV_W     = 4;
  localparam int SIG_OUT   = 0;
  localparam int SIG_RUN   = 1;
  localparam int SIG_DONE  = 2;
  localparam int SIG_RDATA = 3;

  logic                clk = 1'b0;
  logic                rst_n, cfg_we;
  logic [1:0]          cfg_ch, cfg_addr, cnt_sel;
  logic [CNT_W-1:0]    cfg_wdata, cnt_rdata;
  logic [CHANNELS-1:0] start, stop, running, out, done;

  typedef struct {
    int    t;
    int    sig;
    int    ch;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  vslc_timer_bank #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W),
    .DIV_W    (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .start     (start),
    .stop      (stop),
    .running   (running),
    .out       (out),
    .done      (done),
    .cnt_sel   (cnt_sel),
    .cnt_rdata (cnt_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_at(int t, int sig, int ch, int val, string name);
    exp_t e;
    e.t = t; e.sig = sig; e.ch = ch; e.val = val; e.name = name;
    sb.push_back(e);
  endfunction

  function automatic logic [CNT_W-1:0] sample(int sig, int ch);
    case (sig)
      SIG_OUT:  return CNT_W'(out[ch]);
      SIG_RUN:  return CNT_W'(running[ch]);
      SIG_DONE: return CNT_W'(done[ch]);
      default:  return cnt_rdata;
    endcase
  endfunction

  task automatic cfg_write(int ch, int addr, int data);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 2'(addr); cfg_wdata = CNT_W'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_pulse(int ch);
    start = '0;
    start[ch] = 1'b1;
    tick();
    start = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
    start = '0; stop = '0; cnt_sel = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    $display("txn reset released");
    checks++;
    if (running !== 4'b0) begin failures++; $display("FAIL reset_running got=%b exp=0000", running); end
    checks++;
    if (out !== 4'b0) begin failures++; $display("FAIL reset_out got=%b exp=0000", out); end
    checks++;
    if (done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++;
    if (cnt_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%0d exp=0", cnt_rdata); end
  endtask

  task automatic test_cycle();
    exp_t e;
    logic [CNT_W-1:0] a;
    $display("txn cycle ch0 defaults pa=1 pb=2 div=0");
    for (int t = 0; t <= 15; t++) begin
      expect_at(t, SIG_OUT, 0, (t < 15 && (t % 5) >= 2) ? 1 : 0, "cycle_out");
      expect_at(t, SIG_RUN, 0, (t < 15) ? 1 : 0, "cycle_running");
    end
    start_pulse(0);
    for (int t = 0; t <= 15; t++) begin
      if (t > 0) tick();
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        a = sample(e.sig, e.ch);
        checks++;
        if (a !== CNT_W'(e.val)) begin
          failures++;
          $display("FAIL %s t=%0d ch=%0d got=%0d exp=%0d", e.name, t, e.ch, a, e.val);
        end
      end
      stop = (t == 14) ? 4'b0001 : 4'b0000;
    end
    stop = '0;
  endtask

  task automatic test_oneshot();
    exp_t e;
    logic [CNT_W-1:0] a;
    $display("txn oneshot ch1 pa=3 pb=0 div=2");
    cfg_write(1, 0, 3);
    cfg_write(1, 1, 0);
    cfg_write(1, 2, (1 << DIV_W) | 2);
    for (int t = 0; t <= 22; t++) begin
      expect_at(t, SIG_OUT, 1, (t >= 16 && t < 20) ? 1 : 0, "oneshot_out");
      expect_at(t, SIG_DONE, 1, (t == 20) ? 1 : 0, "oneshot_done");
      expect_at(t, SIG_RUN, 1, (t < 20) ? 1 : 0, "oneshot_running");
    end
    start_pulse(1);
    for (int t = 0; t <= 22; t++) begin
      if (t > 0) tick();
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        a = sample(e.sig, e.ch);
        checks++;
        if (a !== CNT_W'(e.val)) begin
          failures++;
          $display("FAIL %s t=%0d ch=%0d got=%0d exp=%0d", e.name, t, e.ch, a, e.val);
        end
      end
    end
  endtask

  task automatic test_retrigger();
    exp_t e;
    logic [CNT_W-1:0] a;
    $display("txn retrigger ch2 pa=5 pb=2 restart at 4");
    cfg_write(2, 0, 5);
    cfg_write(2, 2, 2 << DIV_W);
    for (int t = 0; t <= 15; t++) begin
      expect_at(t, SIG_OUT, 2, (t >= 10 && t < 13) ? 1 : 0, "retrig_out");
      expect_at(t, SIG_DONE, 2, (t == 13) ? 1 : 0, "retrig_done");
      expect_at(t, SIG_RUN, 2, (t < 13) ? 1 : 0, "retrig_running");
    end
    start_pulse(2);
    for (int t = 0; t <= 15; t++) begin
      if (t > 0) tick();
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        a = sample(e.sig, e.ch);
        checks++;
        if (a !== CNT_W'(e.val)) begin
          failures++;
          $display("FAIL %s t=%0d ch=%0d got=%0d exp=%0d", e.name, t, e.ch, a, e.val);
        end
      end
      start = (t == 3) ? 4'b0100 : 4'b0000;
    end
    start = '0;
  endtask

  task automatic test_cfg_running();
    exp_t e;
    logic [CNT_W-1:0] a;
    $display("txn ch3 cycle, period_a=7 written mid-phase, then start+stop");
    for (int t = 0; t <= 33; t++) begin
      expect_at(t, SIG_OUT, 3,
                ((t >= 2 && t < 5) || (t >= 13 && t < 16) || (t >= 24 && t < 27)) ? 1 : 0,
                "cfgrun_out");
      expect_at(t, SIG_RUN, 3, (t < 28) ? 1 : 0, "cfgrun_running");
    end
    cfg_ch = 2'd3; cfg_addr = 2'd0; cfg_wdata = CNT_W'(7);
    start_pulse(3);
    for (int t = 0; t <= 33; t++) begin
      if (t > 0) tick();
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        a = sample(e.sig, e.ch);
        checks++;
        if (a !== CNT_W'(e.val)) begin
          failures++;
          $display("FAIL %s t=%0d ch=%0d got=%0d exp=%0d", e.name, t, e.ch, a, e.val);
        end
      end
      cfg_we = (t == 0);
      start  = (t == 27 || t == 29) ? 4'b1000 : 4'b0000;
      stop   = (t == 27 || t == 29) ? 4'b1000 : 4'b0000;
    end
    cfg_we = 1'b0; start = '0; stop = '0;
  endtask

  task automatic test_readback();
    exp_t e;
    logic [CNT_W-1:0] a;
    $display("txn readback ch0 pa=4 div=0");
    cfg_write(0, 0, 4);
    cfg_write(0, 2, 0);
    cnt_sel = 2'd0;
    for (int t = 0; t <= 7; t++) begin
`ifdef VSLC_TIMER_READBACK_EN
      if (t <= 6) expect_at(t, SIG_RDATA, 0, (t >= 1 && t <= 5) ? t - 1 : 0, "rdata");
`else
      if (t <= 6) expect_at(t, SIG_RDATA, 0, 0, "rdata");
`endif
      expect_at(t, SIG_RUN, 0, (t < 7) ? 1 : 0, "rdata_running");
    end
    start_pulse(0);
    for (int t = 0; t <= 7; t++) begin
      if (t > 0) tick();
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        a = sample(e.sig, e.ch);
        checks++;
        if (a !== CNT_W'(e.val)) begin
          failures++;
          $display("FAIL %s t=%0d ch=%0d got=%0d exp=%0d", e.name, t, e.ch, a, e.val);
        end
      end
      stop = (t == 6) ? 4'b0001 : 4'b0000;
    end
    stop = '0;
  endtask

  task automatic test_stop_and_async_reset();
    exp_t e;
    logic [CNT_W-1:0] a;
    $display("txn stop ch0 oneshot in PHASE_B, then async reset");
    cfg_write(0, 0, 1);
    cfg_write(0, 2, 1 << DIV_W);
    for (int t = 0; t <= 8; t++) begin
      expect_at(t, SIG_OUT, 0, (t == 2 || t == 3) ? 1 : 0, "stop_out");
      expect_at(t, SIG_RUN, 0, (t < 4) ? 1 : 0, "stop_running");
      expect_at(t, SIG_DONE, 0, 0, "stop_done");
    end
    start_pulse(0);
    for (int t = 0; t <= 8; t++) begin
      if (t > 0) tick();
      while (sb.size() > 0 && sb[0].t == t) begin
        e = sb.pop_front();
        a = sample(e.sig, e.ch);
        checks++;
        if (a !== CNT_W'(e.val)) begin
          failures++;
          $display("FAIL %s t=%0d ch=%0d got=%0d exp=%0d", e.name, t, e.ch, a, e.val);
        end
      end
      stop = (t == 3) ? 4'b0001 : 4'b0000;
    end
    stop = '0;
    start_pulse(0);
    start_pulse(3);
    tick();
    checks++;
    if (out[0] !== 1'b1) begin failures++; $display("FAIL prereset_out got=%b exp=1", out[0]); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0) begin failures++; $display("FAIL async_reset_out got=%b exp=0000", out); end
    checks++;
    if (running !== 4'b0) begin failures++; $display("FAIL async_reset_running got=%b exp=0000", running); end
    checks++;
    if (done !== 4'b0) begin failures++; $display("FAIL async_reset_done got=%b exp=0000", done); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_oneshot();
    test_retrigger();
    test_cfg_running();
    test_readback();
    test_stop_and_async_reset();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
